// File: rtl/wvl_pkg.sv
// Shared constants, state encoding and word builders for the EOF framer.
package wvl_pkg;

  localparam int MARK_W   = 8;
  localparam int ROACH_W  = 8;
  localparam int FNUM_W   = 12;
  localparam int TS_W     = 36;
  localparam int PAD_W    = 20;
  localparam int WCNT_W   = 8;
  localparam int EOFCNT_W = 32;
  localparam int WORD_W   = MARK_W + ROACH_W + FNUM_W + TS_W;

  localparam logic [MARK_W-1:0] HDR_MARK  = 8'hFF;
  localparam logic [MARK_W-1:0] TAIL_MARK = 8'hFE;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    BODY = 3'd2,
    TAIL = 3'd3,
    EOFW = 3'd4
  } state_e;

  // Frame header: marker, board id, frame number, timestamp.
  function automatic logic [WORD_W-1:0] hdr_word(input logic [ROACH_W-1:0] id,
                                                 input logic [FNUM_W-1:0]  fnum,
                                                 input logic [TS_W-1:0]    ts);
    return {HDR_MARK, id, fnum, ts};
  endfunction

  // Flush tail: marker, zero pad, timestamp.
  function automatic logic [WORD_W-1:0] tail_word(input logic [TS_W-1:0] ts);
    return {TAIL_MARK, {PAD_W{1'b0}}, ts};
  endfunction

endpackage

// File: rtl/wvl_eof_counter.sv
// Wrapping event counter with increment enable and asynchronous clear.
module wvl_eof_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count enabled events; wraps silently at 2^W.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      count <= '0;
    end else if (inc) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/wvl_eof_framer.sv
// Packetises the photon stream into header-led frames that end with an EOF
// word, closing on a photon-count limit or on a time-slot flush tick.
//
// Handshakes: a word moves on a rising edge where valid && ready are both
// high. valid never depends on ready; once out_valid is up, out_data and
// out_eof hold until the edge that completes the transfer.
module wvl_eof_framer
  import wvl_pkg::*;
#(
  parameter int MAX_PHOTONS = 100,
  parameter int DATA_W      = 64
) (
  input  logic                user_clk,
  input  logic                user_rst_n,
  input  logic                en,
  input  logic [ROACH_W-1:0]  roach_id,
  input  logic [TS_W-1:0]     tstamp,
  input  logic                flush_tick,
  input  logic [DATA_W-1:0]   ph_data,
  input  logic                ph_valid,
  output logic                ph_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic                out_valid,
  output logic                out_eof,
  input  logic                out_ready,
  output logic [FNUM_W-1:0]   frame_num,
  output logic [EOFCNT_W-1:0] n_eof_sent
);

  state_e              state;
  state_e              state_nxt;
  logic [WCNT_W-1:0]   wcnt;
  logic                flush_pend;

  logic                load_ok;
  logic                eof_hs;
  logic                last_word;
  logic                pend_set;
  logic                ld;
  logic [DATA_W-1:0]   ld_data;
  logic                ld_eof;
  logic                wcnt_clr;
  logic                wcnt_inc;
  logic                pend_clr;

  // The output register can take a new word when empty or draining this edge.
  assign load_ok   = !out_valid || out_ready;
  assign eof_hs    = out_valid && out_ready && out_eof;
  assign last_word = ({1'b0, wcnt} + 9'd1) == 9'(MAX_PHOTONS);
  // A flush only matters while a frame is open and not already closing.
  assign pend_set  = flush_tick && ((state == HDR) || (state == BODY));

  // State register.
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state, photon acceptance and output-register load selection.
  always_comb begin
    state_nxt = state;
    ph_ready  = 1'b0;
    ld        = 1'b0;
    ld_data   = '0;
    ld_eof    = 1'b0;
    wcnt_clr  = 1'b0;
    wcnt_inc  = 1'b0;
    pend_clr  = 1'b0;
    case (state)
      IDLE: begin
        if (en && ph_valid && load_ok) begin
          ld        = 1'b1;
          ld_data   = hdr_word(roach_id, frame_num, tstamp);
          wcnt_clr  = 1'b1;
          state_nxt = HDR;
        end
      end
      HDR: begin
        if (out_valid && out_ready) begin
          state_nxt = flush_pend ? TAIL : BODY;
        end
      end
      BODY: begin
        ph_ready = load_ok && !flush_pend;
        if (ph_valid && load_ok && !flush_pend) begin
          ld       = 1'b1;
          ld_data  = ph_data;
          wcnt_inc = 1'b1;
          // The size-limit photon carries the EOF itself, even if a flush
          // arrives on the same edge, so no tail follows it.
          if (last_word) begin
            ld_eof    = 1'b1;
            pend_clr  = 1'b1;
            state_nxt = EOFW;
          end
        end else if (flush_pend) begin
          state_nxt = TAIL;
        end
      end
      TAIL: begin
        if (load_ok) begin
          ld        = 1'b1;
          ld_data   = tail_word(tstamp);
          ld_eof    = 1'b1;
          pend_clr  = 1'b1;
          state_nxt = EOFW;
        end
      end
      EOFW: begin
        if (eof_hs) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output register: load a new word, or drop valid once it has been taken.
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      out_eof   <= 1'b0;
    end else if (ld) begin
      out_data  <= ld_data;
      out_valid <= 1'b1;
      out_eof   <= ld_eof;
    end else if (out_ready) begin
      out_valid <= 1'b0;
      out_eof   <= 1'b0;
    end
  end

  // Photon count within the current frame.
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      wcnt <= '0;
    end else if (wcnt_clr) begin
      wcnt <= '0;
    end else if (wcnt_inc) begin
      wcnt <= wcnt + 8'd1;
    end
  end

  // Pending flush; clearing on any EOF load wins over a same-edge tick.
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      flush_pend <= 1'b0;
    end else if (pend_clr) begin
      flush_pend <= 1'b0;
    end else if (pend_set) begin
      flush_pend <= 1'b1;
    end
  end

  // Completed-frame number, stamped into the next header.
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      frame_num <= '0;
    end else if (eof_hs) begin
      frame_num <= frame_num + 12'd1;
    end
  end

  wvl_eof_counter #(
    .W(EOFCNT_W)
  ) u_eof_cnt (
    .clk   (user_clk),
    .clr_n (user_rst_n),
    .inc   (eof_hs),
    .count (n_eof_sent)
  );

endmodule

// File: tb/tb_wvl_eof_framer.sv
// Directed bench for wvl_eof_framer with a frame-level reference model.
module tb_wvl_eof_framer;

  localparam int MAX = 4;

  logic        user_clk   = 1'b0;
  logic        user_rst_n = 1'b0;
  logic        en         = 1'b0;
  logic [7:0]  roach_id   = 8'h00;
  logic [35:0] tstamp     = 36'h0;
  logic        flush_tick = 1'b0;
  logic [63:0] ph_data    = 64'h0;
  logic        ph_valid   = 1'b0;
  logic        ph_ready;
  logic [63:0] out_data;
  logic        out_valid;
  logic        out_eof;
  logic        out_ready  = 1'b1;
  logic [11:0] frame_num;
  logic [31:0] n_eof_sent;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Stimulus and scoreboard storage: {is_header, eof, data}.
  logic [63:0] ph_q[$];
  logic [65:0] exp_q[$];
  logic [63:0] log_d[$];
  logic        log_e[$];

  // Frame-level model state.
  bit          open_m     = 1'b0;
  bit          closing_m  = 1'b0;
  bit          hdr_done_m = 1'b0;
  int          cnt_m      = 0;
  logic [31:0] n_eof_m    = 32'h0;
  logic [11:0] fn_m       = 12'h0;
  bit          stall_p    = 1'b0;
  logic [63:0] prev_d     = 64'h0;
  logic        prev_e     = 1'b0;

  bit ts_run  = 1'b0;
  bit bp_mode = 1'b0;

  wvl_eof_framer #(
    .MAX_PHOTONS(MAX),
    .DATA_W     (64)
  ) dut (
    .user_clk   (user_clk),
    .user_rst_n (user_rst_n),
    .en         (en),
    .roach_id   (roach_id),
    .tstamp     (tstamp),
    .flush_tick (flush_tick),
    .ph_data    (ph_data),
    .ph_valid   (ph_valid),
    .ph_ready   (ph_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_eof    (out_eof),
    .out_ready  (out_ready),
    .frame_num  (frame_num),
    .n_eof_sent (n_eof_sent)
  );

  // Clock.
  always #5 user_clk = ~user_clk;

  task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge user_clk);
    #1;
  endtask

  task automatic wait_drain(input int limit);
    int n;
    n = 0;
    while ((ph_q.size() != 0 || exp_q.size() != 0) && n < limit) begin
      tick();
      n++;
    end
    repeat (2) tick();
    tests++;
    if (n >= limit) begin
      fails++;
      $display("FAIL drain_timeout: ph_q=%0d exp_q=%0d after %0d cycles", ph_q.size(), exp_q.size(), n);
    end
  endtask

  task automatic pulse_flush();
    @(negedge user_clk);
    flush_tick = 1'b1;
    tick();
    flush_tick = 1'b0;
  endtask

  // Photon source, timestamp and out_ready pattern; updates after each edge.
  initial begin : driver
    bit acc;
    forever begin
      @(negedge user_clk);
      #3;
      acc = user_rst_n && ph_valid && ph_ready;
      @(posedge user_clk);
      #1;
      cyc++;
      if (acc && ph_q.size() > 0) void'(ph_q.pop_front());
      ph_valid  = (ph_q.size() > 0);
      ph_data   = (ph_q.size() > 0) ? ph_q[0] : 64'h0;
      if (ts_run) tstamp = tstamp + 36'd1;
      out_ready = bp_mode ? ((cyc % 3) == 0) : 1'b1;
    end
  end

  // Reference model and compare: sampled just before each rising edge.
  initial begin : model
    bit          exp_rdy;
    bit          hdr_hs;
    bit          eof_hs;
    bit          lim;
    logic [65:0] e;
    forever begin
      @(negedge user_clk);
      #3;
      if (user_rst_n) begin
        chk("n_eof_sent", 66'(n_eof_sent), 66'(n_eof_m));
        chk("frame_num", 66'(frame_num), 66'(fn_m));
        exp_rdy = open_m && hdr_done_m && !closing_m && (!out_valid || out_ready);
        chk("ph_ready", 66'(ph_ready), 66'(exp_rdy));
        if (stall_p) chk("stall_hold", 66'({out_valid, out_eof, out_data}), 66'({1'b1, prev_e, prev_d}));
        stall_p = out_valid && !out_ready;
        prev_d  = out_data;
        prev_e  = out_eof;
        hdr_hs  = 1'b0;
        eof_hs  = 1'b0;
        if (out_valid && out_ready) begin
          log_d.push_back(out_data);
          log_e.push_back(out_eof);
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL extra_word: got %h eof %0d expected none", out_data, out_eof);
          end else begin
            e = exp_q.pop_front();
            chk("out_word", 66'({out_eof, out_data}), 66'(e[64:0]));
            hdr_hs = e[65];
            eof_hs = e[64];
          end
        end
        // Input events at this edge, judged from the frame state before it.
        if (!open_m) begin
          if (en && ph_valid) begin
            exp_q.push_back({1'b1, 1'b0, 8'hFF, roach_id, fn_m, tstamp});
            open_m     = 1'b1;
            closing_m  = 1'b0;
            hdr_done_m = 1'b0;
            cnt_m      = 0;
          end
        end else if (!closing_m) begin
          if (exp_rdy && ph_valid) begin
            cnt_m++;
            lim = (cnt_m == MAX);
            exp_q.push_back({1'b0, lim, ph_data});
            if (lim) closing_m = 1'b1;
          end
          if (!closing_m && flush_tick) begin
            exp_q.push_back({2'b01, 8'hFE, 20'h0, tstamp});
            closing_m = 1'b1;
          end
        end
        if (hdr_hs) hdr_done_m = 1'b1;
        if (eof_hs) begin
          n_eof_m = n_eof_m + 32'd1;
          fn_m    = fn_m + 12'd1;
          open_m  = 1'b0;
        end
      end
    end
  end

  initial begin : main
    logic [63:0] w;
    int          base;
    bit          hit;

    // Reset state, sampled while reset is held.
    repeat (3) tick();
    chk("rst_out_valid", 66'(out_valid), 66'(0));
    chk("rst_out_eof", 66'(out_eof), 66'(0));
    chk("rst_out_data", 66'(out_data), 66'(0));
    chk("rst_ph_ready", 66'(ph_ready), 66'(0));
    chk("rst_frame_num", 66'(frame_num), 66'(0));
    chk("rst_n_eof", 66'(n_eof_sent), 66'(0));
    user_rst_n = 1'b1;
    roach_id   = 8'h5A;
    en         = 1'b1;

    // Size-limited frames: 10 photons, limit 4.
    ts_run = 1'b1;
    for (int i = 0; i < 10; i++) ph_q.push_back(64'hA000_0000_0000_0000 + 64'(i));
    wait_drain(200);
    chk("t1_n_eof", 66'(n_eof_sent), 66'(2));
    chk("t1_frame_num", 66'(frame_num), 66'(2));
    chk("t1_words", 66'(log_d.size()), 66'(13));
    chk("t1_eof_photon", 66'({log_e[4], log_d[4]}), 66'h1_A000_0000_0000_0003);
    w = log_d[0];
    chk("t1_hdr0", 66'(w[63:36]), 66'(28'hFF5A000));
    w = log_d[5];
    chk("t1_hdr1", 66'(w[63:36]), 66'(28'hFF5A001));
    chk("t1_open_frame_last", 66'({log_e[12], log_d[12]}), 66'h0_A000_0000_0000_0009);

    // Flush closes the open frame after 2 photons with a tail word.
    ts_run = 1'b0;
    tstamp = 36'h1_2345_6789;
    tick();
    pulse_flush();
    wait_drain(50);
    chk("t1_tail", 66'({log_e[13], log_d[13]}), 66'h1_FE00_0001_2345_6789);
    chk("t1_n_eof_after_flush", 66'(n_eof_sent), 66'(3));

    // Flush while idle produces nothing.
    pulse_flush();
    repeat (5) tick();
    chk("t2_idle_words", 66'(log_d.size()), 66'(14));
    chk("t2_idle_valid", 66'(out_valid), 66'(0));

    // Flush on the same edge as the size-limit photon.
    for (int i = 0; i < 4; i++) ph_q.push_back(64'hB000_0000_0000_0000 + 64'(i));
    hit = 1'b0;
    for (int i = 0; i < 60 && !hit; i++) begin
      @(negedge user_clk);
      if (ph_valid && ph_ready && ph_data == 64'hB000_0000_0000_0003) hit = 1'b1;
    end
    chk("t3_found_last", 66'(hit), 66'(1));
    flush_tick = 1'b1;
    tick();
    flush_tick = 1'b0;
    wait_drain(50);
    chk("t3_n_eof", 66'(n_eof_sent), 66'(4));
    chk("t3_words", 66'(log_d.size()), 66'(19));
    chk("t3_eof_photon", 66'({log_e[18], log_d[18]}), 66'h1_B000_0000_0000_0003);

    // Backpressure: out_ready one cycle on, two off.
    bp_mode = 1'b1;
    ts_run  = 1'b1;
    for (int i = 0; i < 6; i++) ph_q.push_back(64'hC000_0000_0000_0000 + 64'(i));
    wait_drain(400);
    ts_run = 1'b0;
    tstamp = 36'h0_ABCD_EF01;
    pulse_flush();
    wait_drain(100);
    bp_mode = 1'b0;
    repeat (3) tick();
    chk("t4_n_eof", 66'(n_eof_sent), 66'(6));
    chk("t4_words", 66'(log_d.size()), 66'(28));
    chk("t4_tail", 66'({log_e[27], log_d[27]}), 66'h1_FE00_0000_ABCD_EF01);

    // Reset in the middle of a frame body.
    for (int i = 0; i < 6; i++) ph_q.push_back(64'hD000_0000_0000_0000 + 64'(i));
    hit = 1'b0;
    for (int i = 0; i < 60 && !hit; i++) begin
      @(negedge user_clk);
      if (log_d.size() >= 30) hit = 1'b1;
    end
    chk("t5_reached_body", 66'(hit), 66'(1));
    #1;
    user_rst_n = 1'b0;
    #1;
    chk("t5_async_valid", 66'(out_valid), 66'(0));
    chk("t5_async_n_eof", 66'(n_eof_sent), 66'(0));
    chk("t5_async_frame_num", 66'(frame_num), 66'(0));
    ph_q.delete();
    exp_q.delete();
    open_m     = 1'b0;
    closing_m  = 1'b0;
    hdr_done_m = 1'b0;
    n_eof_m    = 32'h0;
    fn_m       = 12'h0;
    stall_p    = 1'b0;
    repeat (2) tick();
    user_rst_n = 1'b1;
    tstamp     = 36'h0_0000_0042;
    tick();
    base = log_d.size();
    ph_q.push_back(64'hE000_0000_0000_0000);
    wait_drain(50);
    pulse_flush();
    wait_drain(50);
    w = log_d[base];
    chk("t5_hdr_after_reset", 66'(w), 66'(64'hFF5A_0000_0000_0042));
    chk("t5_n_eof", 66'(n_eof_sent), 66'(1));

    // Counter wrap: preload both counters just below their wrap point.
    @(negedge user_clk);
    force dut.u_eof_cnt.count = 32'hFFFF_FFFF;
    force dut.frame_num = 12'hFFF;
    #1;
    release dut.u_eof_cnt.count;
    release dut.frame_num;
    n_eof_m = 32'hFFFF_FFFF;
    fn_m    = 12'hFFF;
    tick();
    base = log_d.size();
    for (int i = 0; i < 4; i++) ph_q.push_back(64'hF000_0000_0000_0000 + 64'(i));
    wait_drain(60);
    w = log_d[base];
    chk("t6_hdr_fnum", 66'(w[63:36]), 66'(28'hFF5AFFF));
    chk("t6_n_eof_wrap", 66'(n_eof_sent), 66'(0));
    chk("t6_frame_num_wrap", 66'(frame_num), 66'(0));

    chk("exp_q_empty", 66'(exp_q.size()), 66'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
